// File: rtl/usb_pkt_pkg.sv
// usb_pkt_pkg: shared constants, FSM encoding and header builder for the USB stream arbiter.
package usb_pkt_pkg;
    localparam logic [7:0] SYNC_DEF     = 8'hA5;
    localparam logic [1:0] SRC_NONE     = 2'b00;
    localparam logic [1:0] SRC_CAM      = 2'b01;
    localparam logic [1:0] SRC_TEL      = 2'b10;
    localparam int         HDR_SYNC_LSB = 24;
    localparam int         HDR_SRC_LSB  = 22;
    localparam int         HDR_SOF_BIT  = 21;
    localparam int         HDR_SEQ_MSB  = 20;
    localparam int         HDR_SEQ_LSB  = 15;
    localparam int         HDR_LEN_MSB  = 14;
    localparam int         TEL_WORDS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    function automatic logic [31:0] make_hdr(input logic [7:0] sync, input logic [1:0] src,
                                             input logic sof, input logic [5:0] seq,
                                             input logic [14:0] len);
        logic [31:0] h;
        h = '0;
        h[31:HDR_SYNC_LSB]              = sync;
        h[HDR_SYNC_LSB-1:HDR_SRC_LSB]   = src;
        h[HDR_SOF_BIT]                  = sof;
        h[HDR_SEQ_MSB:HDR_SEQ_LSB]      = seq;
        h[HDR_LEN_MSB:0]                = len;
        return h;
    endfunction
endpackage

// File: rtl/usb_out_stage.sv
// usb_out_stage: single-entry output register feeding the FIFO write port.
//   load_i/data_i   word offered by the arbiter (taken only when load_ok_o)
//   fifo_full_i     FIFO back-pressure
//   load_ok_o       stage empty or draining this cycle
//   fifo_wr_en_o    write strobe, fifo_data_o registered data
module usb_out_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        fifo_full_i,
    output logic        load_ok_o,
    output logic        fifo_wr_en_o,
    output logic [31:0] fifo_data_o
);
    logic        out_vld_q;
    logic [31:0] out_data_q;

    assign load_ok_o    = ~out_vld_q | ~fifo_full_i;
    assign fifo_wr_en_o = out_vld_q & ~fifo_full_i;
    assign fifo_data_o  = out_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (load_i && load_ok_o) begin
            out_vld_q  <= 1'b1;
            out_data_q <= data_i;
        end else if (fifo_wr_en_o) begin
            out_vld_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/usb_stream_arbiter.sv
// usb_stream_arbiter: round-robin packetiser sharing the USB FIFO between camera and telemetry.
//   enable_i                 grant new packets when high, drain only when low
//   cam_data/valid/sof_i     camera stream, cam_ready_o accept handshake
//   acl_*/mag_*_i            sensor values, snapshotted at telemetry grant
//   fifo_full_i, fifo_wr_en_o, fifo_data_o   FIFO write side
//   grant_src_o              source of the packet in flight, tel_drop_cnt_o lost telemetry requests
module usb_stream_arbiter
    import usb_pkt_pkg::*;
#(
    parameter int         BURST_WORDS = 256,
    parameter int         TEL_PERIOD  = 1000000,
    parameter logic [7:0] SYNC        = SYNC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [31:0] cam_data_i,
    input  logic        cam_valid_i,
    input  logic        cam_sof_i,
    output logic        cam_ready_o,
    input  logic [15:0] acl_x_i,
    input  logic [15:0] acl_y_i,
    input  logic [15:0] acl_z_i,
    input  logic [15:0] mag_x_i,
    input  logic [15:0] mag_y_i,
    input  logic [15:0] mag_z_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
    output logic [31:0] fifo_data_o,
    output logic [1:0]  grant_src_o,
    output logic [7:0]  tel_drop_cnt_o
);
    localparam int TW = $clog2(TEL_PERIOD);

    state_e      state_q;
    logic [1:0]  grant_q;
    logic        last_tel_q;
    logic        tel_pend_q;
    logic [TW-1:0] timer_q;
    logic [7:0]  drop_q;
    logic [5:0]  seq_cam_q, seq_tel_q;
    logic [14:0] cnt_q;
    logic [31:0] hdr_q, tel0_q, tel1_q, tel2_q;

    logic        load_ok, load, is_cam, cam_req, tel_req, pick_tel, grant_now, tel_grant;
    logic        pay_load, last, wrap;
    logic [31:0] load_data;

    assign cam_req   = enable_i & cam_valid_i;
    assign tel_req   = enable_i & tel_pend_q;
    // Telemetry wins a tie unless it was the last source granted; reset makes it win first.
    assign pick_tel  = tel_req & (~cam_req | ~last_tel_q);
    assign grant_now = (state_q == ST_IDLE) & (tel_req | cam_req);
    assign tel_grant = grant_now & pick_tel;
    assign is_cam    = grant_q == SRC_CAM;
    assign cam_ready_o = (state_q == ST_PAY) & is_cam & load_ok;
    assign pay_load  = (state_q == ST_PAY) & load_ok & (~is_cam | cam_valid_i);
    assign load      = ((state_q == ST_HDR) & load_ok) | pay_load;
    assign last      = pay_load & (cnt_q == (is_cam ? 15'(BURST_WORDS - 1) : 15'(TEL_WORDS - 1)));
    assign load_data = (state_q == ST_HDR) ? hdr_q :
                       is_cam               ? cam_data_i :
                       cnt_q[1]             ? tel2_q :
                       cnt_q[0]             ? tel1_q : tel0_q;
    assign wrap      = enable_i & (timer_q == TW'(TEL_PERIOD - 1));
    assign grant_src_o    = grant_q;
    assign tel_drop_cnt_o = drop_q;

    usb_out_stage u_out (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (load),
        .data_i       (load_data),
        .fifo_full_i  (fifo_full_i),
        .load_ok_o    (load_ok),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o)
    );

    // A request arriving in the same cycle as the grant that consumes the old one is kept, not dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q    <= '0;
            tel_pend_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            timer_q    <= (!enable_i || wrap) ? '0 : timer_q + TW'(1);
            tel_pend_q <= wrap | (tel_pend_q & ~tel_grant);
            if (wrap && tel_pend_q && !tel_grant && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= SRC_NONE;
            last_tel_q <= 1'b0;
            seq_cam_q  <= '0;
            seq_tel_q  <= '0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            tel0_q     <= '0;
            tel1_q     <= '0;
            tel2_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (grant_now) begin
                    grant_q    <= pick_tel ? SRC_TEL : SRC_CAM;
                    last_tel_q <= pick_tel;
                    hdr_q      <= pick_tel ? make_hdr(SYNC, SRC_TEL, 1'b0, seq_tel_q, 15'(TEL_WORDS))
                                           : make_hdr(SYNC, SRC_CAM, cam_sof_i, seq_cam_q, 15'(BURST_WORDS));
                    if (pick_tel) begin
                        tel0_q <= {acl_x_i, acl_y_i};
                        tel1_q <= {acl_z_i, mag_x_i};
                        tel2_q <= {mag_y_i, mag_z_i};
                    end
                    state_q <= ST_HDR;
                end
                ST_HDR: if (load_ok) begin
                    cnt_q   <= '0;
                    state_q <= ST_PAY;
                end
                ST_PAY: if (pay_load) begin
                    cnt_q <= cnt_q + 15'd1;
                    if (last) begin
                        if (is_cam) seq_cam_q <= seq_cam_q + 6'd1;
                        else        seq_tel_q <= seq_tel_q + 6'd1;
                        grant_q <= SRC_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
